uart_tx: RTL and testbench
==========================

# uart_tx

UART transmitter: the sending end of the serial link whose receiver runs in the same clock domain. It accepts bytes from an upstream producer over a valid/ready handshake and serialises each byte as one start bit, 8 data bits (LSB first), an optional parity bit and one stop bit on an idle-high line. A one-byte holding register lets the producer hand over the next byte while the current frame is still on the wire, so consecutive frames are sent with no idle gap.

## Interface
- clk_frequency, 27, clock frequency in MHz
- baud_rate, 115200, serial bit rate
- i_clk  input  1  clock
- i_rst  input  1  synchronous reset, active-high
- i_tx_valid  input  1  producer has a byte on i_tx_byte
- i_tx_byte  input  8  byte to send
- o_tx_ready  output  1  holding register empty; byte accepted on i_tx_valid & o_tx_ready
- o_serial  output  1  serial line, idle high, registered
- o_busy  output  1  frame in progress (start through stop)
- o_done  output  1  one-cycle pulse at the end of each stop bit

## Operation
- clk_cycle = (clk_frequency*1000000)/baud_rate, which is 234 at the defaults. Legal range is 2..65535. The bit counter is 16 bits wide.
- FSM states: S_IDLE, S_START, S_DATA, S_PARITY (only with the feature macro), S_STOP.
- S_IDLE: o_serial=1. If the holding register is full, load the shifter from it, clear the holding register and go to S_START.
- S_START: o_serial=0 for clk_cycle cycles, then go to S_DATA with bit_index=0.
- S_DATA: o_serial=shifter[bit_index] for clk_cycle cycles per bit. After bit 7 go to S_PARITY if the feature is compiled in, otherwise to S_STOP.
- S_PARITY: o_serial = XOR of the 8 data bits (even parity) for clk_cycle cycles, then go to S_STOP.
- S_STOP: o_serial=1 for clk_cycle cycles. On the last cycle assert o_done.
  - If the holding register is full: load the shifter and go straight to S_START.
  - Otherwise go to S_IDLE.
- Holding register: written on i_tx_valid & o_tx_ready. o_tx_ready = ~hold_full, driven from a register.
  - A transfer from the holding register to the shifter and a new write can occur on the same edge only when the holding register is empty, which is impossible. Writes and transfers are therefore mutually exclusive.
- i_tx_byte is sampled only on the accepting edge. Later changes have no effect.
- i_tx_valid without o_tx_ready: the byte is not taken. The producer holds valid/byte.

## Timing
- Reset values: o_serial=1, o_tx_ready=1, o_busy=0, o_done=0. The FSM is in S_IDLE, the holding register is empty and the counters are 0.
- Accept at edge N from idle:
  - the holding register is full after N;
  - the FSM enters S_START and o_serial=0 after N+1;
  - o_tx_ready is back to 1 after N+1.
- Each bit lasts exactly clk_cycle cycles.
- Frame length is 10*clk_cycle cycles without parity and 11*clk_cycle with parity.
- o_done is high for exactly the one cycle after the final stop-bit cycle edge.
- Back-to-back: the next start bit begins on the cycle immediately after the last stop-bit cycle, with zero idle cycles.
- o_busy=1 from S_START entry through the last S_STOP cycle. It stays 1 across back-to-back frames.
- Reset asserted mid-frame: on the next edge o_serial=1 and the pending byte is discarded. No o_done is produced for the aborted frame.

## Configuration
- UART_TX_PARITY_EN defined: S_PARITY is present and an even-parity bit is inserted between data bit 7 and the stop bit.
- Undefined: no parity state, and frames are 10 bits.

## Structure
- Shared package uart_pkg holds:
  - FSM state encodings (3-bit);
  - the data-bit count constant (8);
  - the clk_cycle computation, shared with the receiver.
- One sub-module, uart_baud_counter: a 16-bit counter with synchronous clear that outputs a bit_end strobe when the count reaches clk_cycle-1. It is reused per bit.

## Test plan
- Single byte 0xA5 from idle, no parity: o_serial sequence 0,1,0,1,0,0,1,0,1,1, each bit 234 cycles. o_done pulses once, 2340 cycles after the start bit begins.
- Bytes 0x55 then 0x0F, with 0x0F offered while 0x55 is on the wire: 0x0F is accepted during the first frame (o_tx_ready drops then rises). The second start bit follows the first stop bit with 0 idle cycles. o_busy stays 1 throughout.
- Valid asserted with byte 0x33 while the holding register is full: no acceptance until o_tx_ready=1. The byte is not corrupted or duplicated.
- Reset pulsed during data bit 3 of 0xFF: o_serial=1 the next cycle, no o_done, o_tx_ready=1. A following 0x01 is transmitted correctly.
- With UART_TX_PARITY_EN: 0x07 gives a parity bit of 1 and 0x03 gives a parity bit of 0. Frame length is 11*234 cycles.
- Small divider with clk_frequency=1, baud_rate=500000 (clk_cycle=2): 0x81 is sent with every bit exactly 2 cycles long.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmitter and receiver:
//   - uart_state_e   : 3-bit FSM state encoding
//   - DATA_BITS      : data bits per frame (8)
//   - LAST_BIT       : index of the final data bit
//   - calc_clk_cycle : clock cycles per serial bit from MHz / baud
//   - even_parity    : XOR of a data byte
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_e;

  // Clock cycles per bit; legal results are 2..65535.
  function automatic logic [15:0] calc_clk_cycle(input int unsigned clk_mhz,
                                                 input int unsigned baud);
    int unsigned cyc;
    cyc = (clk_mhz * 32'd1000000) / baud;
    return cyc[15:0];
  endfunction

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// -----------------------------------------------------------------------------
// uart_tx_if
// Byte handshake between a producer and the UART transmitter.
//   i_tx_valid : producer offers i_tx_byte
//   i_tx_byte  : byte to send
//   o_tx_ready : transmitter holding register empty
// Modports: master (producer), slave (transmitter).
// -----------------------------------------------------------------------------
interface uart_tx_if;

  logic       i_tx_valid;
  logic [7:0] i_tx_byte;
  logic       o_tx_ready;

  modport master (output i_tx_valid, output i_tx_byte, input o_tx_ready);
  modport slave  (input i_tx_valid, input i_tx_byte, output o_tx_ready);

endinterface

// File: rtl/uart_baud_counter.sv
// -----------------------------------------------------------------------------
// uart_baud_counter
// 16-bit bit-period counter. Counts 0..CLK_CYCLE-1 and wraps; bit_end_o is
// high on the final cycle of each bit period.
//   clk_i     : clock
//   rst_i     : synchronous reset, active-high
//   clear_i   : synchronous clear (held while the line is idle)
//   bit_end_o : last cycle of the current bit period
// -----------------------------------------------------------------------------
module uart_baud_counter #(
  parameter logic [15:0] CLK_CYCLE = 16'd234
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic bit_end_o
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  assign bit_end_o = (count_q == (CLK_CYCLE - 16'd1));

  // Next count: wrap at the end of each bit so the counter is reused per bit.
  always_comb begin
    count_d = count_q;
    if (clear_i || bit_end_o) begin
      count_d = 16'd0;
    end else begin
      count_d = count_q + 16'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// UART transmitter: start bit, 8 data bits LSB first, optional even parity,
// one stop bit on an idle-high line. A one-byte holding register lets the
// next byte be accepted while a frame is on the wire, so frames run back to
// back with no idle gap.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between data bit 7 and the stop bit.
// Ports:
//   i_clk    : clock
//   i_rst    : synchronous reset, active-high
//   tx_if    : byte handshake (slave modport)
//   o_serial : serial line, idle high, registered
//   o_busy   : frame in progress (start through stop)
//   o_done   : one-cycle pulse after the final stop-bit cycle
// -----------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned clk_frequency = 27,
  parameter int unsigned baud_rate     = 115200
) (
  input  logic       i_clk,
  input  logic       i_rst,
  uart_tx_if.slave   tx_if,
  output logic       o_serial,
  output logic       o_busy,
  output logic       o_done
);

  localparam logic [15:0] CLK_CYCLE = calc_clk_cycle(clk_frequency, baud_rate);

  uart_state_e state_q;
  logic [7:0]  shifter_q;
  logic [2:0]  bit_index_q;
  logic [7:0]  hold_q;
  logic        hold_full_q;
  logic        tx_ready_q;
  logic        serial_q;
  logic        busy_q;
  logic        done_q;
  logic        bit_end_s;

  uart_baud_counter #(
    .CLK_CYCLE (CLK_CYCLE)
  ) u_baud (
    .clk_i     (i_clk),
    .rst_i     (i_rst),
    .clear_i   (state_q == S_IDLE),
    .bit_end_o (bit_end_s)
  );

  assign tx_if.o_tx_ready = tx_ready_q;
  assign o_serial         = serial_q;
  assign o_busy           = busy_q;
  assign o_done           = done_q;

  // Holding register plus transmit FSM with registered line outputs.
  // A write needs the holding register empty and a transfer needs it full,
  // so the two never collide on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      shifter_q   <= 8'd0;
      bit_index_q <= 3'd0;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      tx_ready_q  <= 1'b1;
      serial_q    <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (tx_if.i_tx_valid && tx_ready_q) begin
        hold_q      <= tx_if.i_tx_byte;
        hold_full_q <= 1'b1;
        tx_ready_q  <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          serial_q <= 1'b1;
          busy_q   <= 1'b0;
          if (hold_full_q) begin
            shifter_q   <= hold_q;
            hold_full_q <= 1'b0;
            tx_ready_q  <= 1'b1;
            state_q     <= S_START;
            serial_q    <= 1'b0;
            busy_q      <= 1'b1;
          end
        end

        S_START: begin
          if (bit_end_s) begin
            state_q     <= S_DATA;
            bit_index_q <= 3'd0;
            serial_q    <= shifter_q[0];
          end
        end

        S_DATA: begin
          if (bit_end_s) begin
            if (bit_index_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              state_q  <= S_PARITY;
              serial_q <= even_parity(shifter_q);
`else
              state_q  <= S_STOP;
              serial_q <= 1'b1;
`endif
            end else begin
              bit_index_q <= bit_index_q + 3'd1;
              serial_q    <= shifter_q[bit_index_q + 3'd1];
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end_s) begin
            state_q  <= S_STOP;
            serial_q <= 1'b1;
          end
        end
`endif

        S_STOP: begin
          if (bit_end_s) begin
            done_q <= 1'b1;
            if (hold_full_q) begin
              // Chain straight into the next start bit: no idle cycle.
              shifter_q   <= hold_q;
              hold_full_q <= 1'b0;
              tx_ready_q  <= 1'b1;
              state_q     <= S_START;
              serial_q    <= 1'b0;
            end else begin
              state_q  <= S_IDLE;
              serial_q <= 1'b1;
              busy_q   <= 1'b0;
            end
          end
        end

        default: begin
          state_q  <= S_IDLE;
          serial_q <= 1'b1;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Scoreboard bench for uart_tx. The driver pushes the hand-built expected
// frame when a byte is accepted; monitors pop and compare each frame as it
// appears on the serial line, including o_done timing and o_busy.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  localparam int CYC  = 234;
  localparam int CYC2 = 2;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  typedef struct {
    logic [10:0] bits;
    logic [7:0]  data;
    logic        par;
    bit          b2b;
  } frame_t;

  logic clk = 1'b0;
  logic rst;
  logic serial, busy, done;
  logic serial2, busy2, done2;

  frame_t sbq[$];
  frame_t sbq2[$];

  int checks   = 0;
  int failures = 0;

  // Monitor state for the main DUT.
  bit     mon_active = 1'b0;
  bit     mon_pend   = 1'b0;
  bit     mon_bad_busy, mon_bad_done, mon_bad_bit;
  logic   mon_bitval;
  int     mon_bidx, mon_cnt;
  frame_t mon_cur;
  bit     mon2_active = 1'b0;

  always #5 clk = ~clk;

  uart_tx_if tx_if ();
  uart_tx_if tx2_if ();

  uart_tx dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .tx_if    (tx_if),
    .o_serial (serial),
    .o_busy   (busy),
    .o_done   (done)
  );

  uart_tx #(
    .clk_frequency (1),
    .baud_rate     (500000)
  ) dut2 (
    .i_clk    (clk),
    .i_rst    (rst),
    .tx_if    (tx2_if),
    .o_serial (serial2),
    .o_busy   (busy2),
    .o_done   (done2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic frame_t make_frame(input logic [7:0] b, input logic par, input bit b2b);
    frame_t f;
    f.bits      = 11'h7FF;
    f.bits[0]   = 1'b0;
    f.bits[8:1] = b;
`ifdef UART_TX_PARITY_EN
    f.bits[9]   = par;
`endif
    f.data = b;
    f.par  = par;
    f.b2b  = b2b;
    return f;
  endfunction

  // Offer a byte on the main DUT; push the expected frame on acceptance.
  task automatic send(input logic [7:0] b, input logic par, input bit b2b);
    int waited = 0;
    tx_if.i_tx_valid = 1'b1;
    tx_if.i_tx_byte  = b;
    @(negedge clk);
    while (!tx_if.o_tx_ready) begin
      waited++;
      if (waited > 4 * NBITS * CYC) begin
        check("accept_timeout", waited, 0);
        tx_if.i_tx_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    sbq.push_back(make_frame(b, par, b2b));
    tx_if.i_tx_valid = 1'b0;
    tx_if.i_tx_byte  = ~b;
  endtask

  // Wait until every queued frame has been seen and the DUT is idle.
  task automatic wait_idle();
    int waited = 0;
    @(negedge clk);
    while (sbq.size() != 0 || mon_active || mon_pend || busy) begin
      waited++;
      if (waited > 8 * NBITS * CYC) begin
        check("idle_timeout", waited, 0);
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  // Main-DUT monitor: per-bit line values, o_done timing, o_busy, gap.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_active = 1'b0;
        mon_pend   = 1'b0;
      end else begin
        if (mon_pend) begin
          mon_pend = 1'b0;
          check($sformatf("done_pulse_%02h", mon_cur.data), done, 1);
          if (sbq.size() > 0 && sbq[0].b2b) begin
            check($sformatf("b2b_start_%02h", sbq[0].data), serial, 0);
            check($sformatf("b2b_busy_%02h", sbq[0].data), busy, 1);
          end else begin
            check($sformatf("busy_clear_%02h", mon_cur.data), busy, 0);
          end
        end else if (done && !mon_active) begin
          check("spurious_done", done, 0);
        end

        if (!mon_active && serial == 1'b0) begin
          check("frame_expected", (sbq.size() > 0) ? 1 : 0, 1);
          if (sbq.size() > 0) begin
            mon_cur      = sbq.pop_front();
            mon_active   = 1'b1;
            mon_bidx     = 0;
            mon_cnt      = 0;
            mon_bad_busy = 1'b0;
            mon_bad_done = 1'b0;
          end
        end

        if (mon_active) begin
          if (mon_cnt == 0) begin
            mon_bitval  = serial;
            mon_bad_bit = 1'b0;
          end
          if (serial !== mon_cur.bits[mon_bidx] && !mon_bad_bit) begin
            mon_bitval  = serial;
            mon_bad_bit = 1'b1;
          end
          if (busy !== 1'b1) mon_bad_busy = 1'b1;
          if (done !== 1'b0 && (mon_bidx != 0 || mon_cnt != 0)) mon_bad_done = 1'b1;
          mon_cnt++;
          if (mon_cnt == CYC) begin
            check($sformatf("frame_%02h_bit%0d", mon_cur.data, mon_bidx),
                  mon_bitval, mon_cur.bits[mon_bidx]);
            mon_bidx++;
            mon_cnt = 0;
            if (mon_bidx == NBITS) begin
              check($sformatf("frame_%02h_busy_low", mon_cur.data), mon_bad_busy, 0);
              check($sformatf("frame_%02h_early_done", mon_cur.data), mon_bad_done, 0);
              mon_active = 1'b0;
              mon_pend   = 1'b1;
            end
          end
        end
      end
    end
  end

  // Small-divider DUT monitor: every cycle of every bit compared.
  initial begin
    frame_t f;
    forever begin
      @(negedge clk);
      if (!rst && serial2 == 1'b0) begin
        check("dut2_frame_expected", (sbq2.size() > 0) ? 1 : 0, 1);
        if (sbq2.size() > 0) begin
          mon2_active = 1'b1;
          f = sbq2.pop_front();
          for (int b = 0; b < NBITS; b++) begin
            for (int c = 0; c < CYC2; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              check($sformatf("dut2_bit%0d_cyc%0d", b, c), serial2, f.bits[b]);
            end
          end
          @(negedge clk);
          check("dut2_done", done2, 1);
          mon2_active = 1'b0;
        end
      end
    end
  end

  // Hang guard.
  initial begin
    #(900000 * 10);
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int   waited;
    logic seen_done;

    rst               = 1'b1;
    tx_if.i_tx_valid  = 1'b0;
    tx_if.i_tx_byte   = 8'h00;
    tx2_if.i_tx_valid = 1'b0;
    tx2_if.i_tx_byte  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_serial", serial, 1);
    check("reset_ready", tx_if.o_tx_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);

    // Single byte from idle, with accept latency.
    send(8'hA5, 1'b0, 1'b0);
    check("accept_ready_low", tx_if.o_tx_ready, 0);
    check("accept_serial_idle", serial, 1);
    @(posedge clk);
    #1;
    check("start_serial_low", serial, 0);
    check("start_ready_back", tx_if.o_tx_ready, 1);
    check("start_busy", busy, 1);
    wait_idle();

    // Second byte offered mid-frame: back to back.
    send(8'h55, 1'b0, 1'b0);
    repeat (500) @(posedge clk);
    #1;
    send(8'h0F, 1'b0, 1'b1);
    check("hold_full_ready_low", tx_if.o_tx_ready, 0);
    wait_idle();
    check("idle_ready", tx_if.o_tx_ready, 1);

    // Byte offered while the holding register is full.
    send(8'hC3, 1'b0, 1'b0);
    send(8'h3C, 1'b0, 1'b1);
    check("offer_while_full", tx_if.o_tx_ready, 0);
    send(8'h33, 1'b0, 1'b1);
    wait_idle();

    // Reset during data bit 3 of 0xFF.
    send(8'hFF, 1'b0, 1'b0);
    repeat (1 + 4 * CYC + 100) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_serial", serial, 1);
    check("abort_ready", tx_if.o_tx_ready, 1);
    check("abort_busy", busy, 0);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 12 * CYC; i++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("abort_no_done", seen_done, 0);
    @(posedge clk);
    #1;
    send(8'h01, 1'b1, 1'b0);
    wait_idle();

    // Parity vectors (plain frames when parity is not built in).
    send(8'h07, 1'b1, 1'b0);
    send(8'h03, 1'b0, 1'b1);
    wait_idle();

    // Small divider: two cycles per bit.
    tx2_if.i_tx_valid = 1'b1;
    tx2_if.i_tx_byte  = 8'h81;
    waited = 0;
    @(negedge clk);
    while (!tx2_if.o_tx_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    check("dut2_ready", tx2_if.o_tx_ready, 1);
    @(posedge clk);
    #1;
    sbq2.push_back(make_frame(8'h81, 1'b0, 1'b0));
    tx2_if.i_tx_valid = 1'b0;
    tx2_if.i_tx_byte  = 8'h00;
    waited = 0;
    while ((sbq2.size() != 0 || mon2_active) && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    check("dut2_queue_empty", sbq2.size(), 0);
    check("dut2_monitor_idle", mon2_active, 0);
    check("sb_empty", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
